flag_stack_reg: RTL

//  Parametrised processor status-flag register with a hardware save/restore stack.

---
 rtl/flag_stack_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/flag_stack_reg.sv
// Status-flag register with masked ALU update, sticky accumulation and a
// LIFO save/restore stack for call/interrupt entry and return.
module flag_stack_reg #(
  parameter int NUM_FLAGS = 4,
  parameter int DEPTH     = 4,
  parameter int DW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 update_en,
  input  logic [NUM_FLAGS-1:0] update_mask,
  input  logic [NUM_FLAGS-1:0] flags_in,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 sticky_clr,
  output logic [NUM_FLAGS-1:0] flags_out,
  output logic [NUM_FLAGS-1:0] sticky_out,
  output logic [DW-1:0]        depth_out,
  output logic                 full,
  output logic                 empty,
  output logic                 stack_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_FLAGS-1:0] mem [DEPTH];
  logic [NUM_FLAGS-1:0] flags_q;
  logic [NUM_FLAGS-1:0] sticky_q;
  logic [DW-1:0]        depth_q;
  logic                 err_q;

  logic                 do_push;
  logic                 do_pop;
  logic                 collide;
  logic                 is_full;
  logic                 is_empty;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 err_now;
  logic [NUM_FLAGS-1:0] upd_flags;
  logic [NUM_FLAGS-1:0] new_set;
  logic [DW-1:0]        depth_m1;
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        rd_idx;

  assign do_push  = push & ~pop;
  assign do_pop   = pop & ~push;
  assign collide  = push & pop;
  assign is_full  = (depth_q == DW'(DEPTH));
  assign is_empty = (depth_q == '0);
  assign push_ok  = do_push & ~is_full;
  assign pop_ok   = do_pop & ~is_empty;
  assign err_now  = (do_push & is_full) | (do_pop & is_empty) | collide;

  assign upd_flags = update_en ? ((update_mask & flags_in) | (~update_mask & flags_q))
                               : flags_q;
  assign new_set   = {NUM_FLAGS{update_en}} & update_mask & flags_in;

  // Slot indices: writes land at depth (only when not full), reads come from
  // depth-1 (only when not empty), so both always fit in AW bits.
  assign depth_m1 = depth_q - DW'(1);
  assign wr_idx   = depth_q[AW-1:0];
  assign rd_idx   = depth_m1[AW-1:0];

  // Stack storage holds no reset: entries above depth are never read.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_idx] <= flags_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= '0;
      sticky_q <= '0;
      depth_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // A successful pop restores the saved flags and discards the ALU update.
      flags_q  <= pop_ok ? mem[rd_idx] : upd_flags;
      sticky_q <= (sticky_clr ? '0 : sticky_q) | new_set;
      if (push_ok) begin
        depth_q <= depth_q + DW'(1);
      end else if (pop_ok) begin
        depth_q <= depth_m1;
      end
      if (err_now) begin
        err_q <= 1'b1;
      end else if (sticky_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign flags_out  = flags_q;
  assign sticky_out = sticky_q;
  assign depth_out  = depth_q;
  assign full       = is_full;
  assign empty      = is_empty;
  assign stack_err  = err_q;

endmodule
